// File: rtl/store_queue.sv
// Store queue: holds issued stores until the ROB commits them, drains committed
// stores in order to memory, and forwards store data to younger loads.
module store_queue #(
  parameter int DEPTH = 8,
  parameter int ROB_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_valid,
  input  logic [ROB_W-1:0] alloc_rob_tag,
  input  logic [31:0]      alloc_base,
  input  logic [31:0]      alloc_imm,
  input  logic [31:0]      alloc_data,
  input  logic [1:0]       alloc_size,
  input  logic             retire_valid,
  input  logic [ROB_W-1:0] rob_head,
  input  logic             flush,
  output logic             mem_wr_valid,
  output logic [31:0]      mem_wr_addr,
  output logic [31:0]      mem_wr_data,
  output logic [3:0]       mem_wr_be,
  input  logic             mem_wr_ready,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  input  logic [1:0]       ld_size,
  output logic             fwd_hit,
  output logic [31:0]      fwd_data,
  output logic             fwd_stall,
  output logic             full,
  output logic             empty,
  output logic [$clog2(DEPTH):0] count,
  output logic             misalign_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entry state is implied by position: offsets [0, commit_cnt) from head are
  // COMMITTED, [commit_cnt, count_q) are PENDING, the rest are FREE.
  logic [31:0]      e_addr [DEPTH];
  logic [31:0]      e_data [DEPTH];
  logic [1:0]       e_size [DEPTH];
  logic [ROB_W-1:0] e_tag  [DEPTH];

  logic [PW-1:0] head, tail, head_next, pend_idx;
  logic [CW-1:0] count_q, commit_cnt, commit_next;

  logic [31:0] alloc_addr;
  logic        alloc_legal, alloc_fire, misalign_set;
  logic        commit_fire, drain;
  logic [1:0]  head_off;

  function automatic logic [3:0] size_mask(input logic [1:0] s);
    case (s)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  assign alloc_addr  = alloc_base + alloc_imm;
  assign alloc_legal = (alloc_size != 2'b11) &&
                       !(alloc_size == 2'b01 && alloc_addr[0]) &&
                       !(alloc_size == 2'b10 && alloc_addr[1:0] != 2'b00);

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  assign alloc_fire   = alloc_valid & ~full & ~flush & alloc_legal;
  assign misalign_set = alloc_valid & ~full & ~alloc_legal;

  assign pend_idx    = head + commit_cnt[PW-1:0];
  assign commit_fire = retire_valid && (commit_cnt < count_q) && (e_tag[pend_idx] == rob_head);

  assign mem_wr_valid = (commit_cnt != '0);
  assign drain        = mem_wr_valid & mem_wr_ready;
  assign head_off     = e_addr[head][1:0];
  assign mem_wr_addr  = {e_addr[head][31:2], 2'b00};
  assign mem_wr_data  = e_data[head] << {head_off, 3'b000};
  assign mem_wr_be    = 4'(size_mask(e_size[head]) << head_off);

  assign head_next   = head + PW'(drain);
  assign commit_next = commit_cnt + CW'(commit_fire) - CW'(drain);

  always_ff @(posedge clk) begin
    if (!reset) begin
      head         <= '0;
      tail         <= '0;
      count_q      <= '0;
      commit_cnt   <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= misalign_set;
      head         <= head_next;
      commit_cnt   <= commit_next;
      if (flush) begin
        // Retire is applied before the squash, so a same-cycle commit survives.
        count_q <= commit_next;
        tail    <= head_next + commit_next[PW-1:0];
      end else begin
        count_q <= count_q + CW'(alloc_fire) - CW'(drain);
        tail    <= tail + PW'(alloc_fire);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      e_addr[tail] <= alloc_addr;
      e_data[tail] <= alloc_data;
      e_size[tail] <= alloc_size;
      e_tag[tail]  <= alloc_rob_tag;
    end
  end

  logic [3:0]    ld_mask, f_mask, f_ov;
  logic [PW-1:0] f_idx;
  logic          fwd_any, fwd_part;
  logic [31:0]   fwd_sel, ld_ext;

  // Scan oldest to youngest so the last overlapping entry seen is the youngest.
  always_comb begin
    fwd_any  = 1'b0;
    fwd_part = 1'b0;
    fwd_sel  = '0;
    f_idx    = '0;
    f_mask   = '0;
    f_ov     = '0;
    ld_mask  = 4'(size_mask(ld_size) << ld_addr[1:0]);
    for (int i = 0; i < DEPTH; i++) begin
      f_idx  = head + PW'(i);
      f_mask = 4'(size_mask(e_size[f_idx]) << e_addr[f_idx][1:0]);
      f_ov   = f_mask & ld_mask;
      if ((CW'(i) < count_q) && (e_addr[f_idx][31:2] == ld_addr[31:2]) && (f_ov != 4'b0000)) begin
        fwd_any = 1'b1;
        if (f_ov != ld_mask) fwd_part = 1'b1;
        fwd_sel = (e_data[f_idx] << {e_addr[f_idx][1:0], 3'b000}) >> {ld_addr[1:0], 3'b000};
      end
    end
  end

  always_comb begin
    case (ld_size)
      2'b00:   ld_ext = 32'h0000_00FF;
      2'b01:   ld_ext = 32'h0000_FFFF;
      default: ld_ext = 32'hFFFF_FFFF;
    endcase
  end

  assign fwd_stall = ld_valid & fwd_part;
  assign fwd_hit   = ld_valid & fwd_any & ~fwd_part;
  assign fwd_data  = fwd_hit ? (fwd_sel & ld_ext) : 32'h0;

endmodule

// File: tb/tb_store_queue.sv
// Scoreboard bench for store_queue: a queue-based reference model predicts status
// and forwarding each cycle; expected memory writes are queued at commit time.
module tb_store_queue;
  localparam int DEPTH = 8;
  localparam int ROB_W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, alloc_valid, retire_valid, flush, mem_wr_ready, ld_valid;
  logic [ROB_W-1:0] alloc_rob_tag, rob_head;
  logic [31:0]      alloc_base, alloc_imm, alloc_data, ld_addr;
  logic [1:0]       alloc_size, ld_size;
  logic             mem_wr_valid, fwd_hit, fwd_stall, full, empty, misalign_err;
  logic [31:0]      mem_wr_addr, mem_wr_data, fwd_data;
  logic [3:0]       mem_wr_be;
  logic [$clog2(DEPTH):0] count;

  store_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_rob_tag(alloc_rob_tag), .alloc_base(alloc_base),
    .alloc_imm(alloc_imm), .alloc_data(alloc_data), .alloc_size(alloc_size),
    .retire_valid(retire_valid), .rob_head(rob_head), .flush(flush),
    .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_be(mem_wr_be), .mem_wr_ready(mem_wr_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall),
    .full(full), .empty(empty), .count(count), .misalign_err(misalign_err)
  );

  typedef struct {
    logic [31:0]      addr;
    logic [31:0]      data;
    int               nb;
    logic [ROB_W-1:0] tag;
    bit               com;
  } ent_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  ent_t sq[$];
  wr_t  exp_wr[$];
  bit   m_mis = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  task automatic idle();
    reset = 1'b1; alloc_valid = 1'b0; alloc_rob_tag = '0; alloc_base = '0; alloc_imm = '0;
    alloc_data = '0; alloc_size = 2'b10; retire_valid = 1'b0; rob_head = '0; flush = 1'b0;
    mem_wr_ready = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_size = 2'b10;
  endtask

  task automatic store(input logic [ROB_W-1:0] tag, input logic [31:0] base, input logic [31:0] imm,
                       input logic [31:0] data, input logic [1:0] size);
    alloc_valid = 1'b1; alloc_rob_tag = tag; alloc_base = base; alloc_imm = imm;
    alloc_data = data; alloc_size = size;
  endtask

  // Compare this cycle's outputs with the model, advance the model across the
  // coming clock edge, then return at the following falling edge.
  task automatic step();
    int          cnt, pend, ln, off, was_full, drain, legal;
    bit          ov, cov, any, part;
    logic [31:0] fd, cand, b, a;
    wr_t         w;
    ent_t        e;
    #1;
    cnt = sq.size();
    chk("count", 32'(count), 32'(cnt));
    chk("full", 32'(full), 32'(cnt == DEPTH));
    chk("empty", 32'(empty), 32'(cnt == 0));
    chk("mem_wr_valid", 32'(mem_wr_valid), 32'(cnt > 0 && sq[0].com));
    chk("misalign_err", 32'(misalign_err), 32'(m_mis));
    any = 0; part = 0; fd = 0;
    if (ld_valid) begin
      ln = nbytes(ld_size);
      foreach (sq[j]) begin
        ov = 0; cov = 1; cand = 0;
        for (int k = 0; k < ln; k++) begin
          b = ld_addr + 32'(k);
          if (b - sq[j].addr < 32'(sq[j].nb)) begin
            ov = 1;
            off = int'(b - sq[j].addr);
            cand[8*k +: 8] = sq[j].data[8*off +: 8];
          end else cov = 0;
        end
        if (ov) begin
          any = 1;
          if (!cov) part = 1;
          fd = cand;
        end
      end
    end
    chk("fwd_hit", 32'(fwd_hit), 32'(any && !part));
    chk("fwd_stall", 32'(fwd_stall), 32'(part));
    chk("fwd_data", fwd_data, (any && !part) ? fd : 32'h0);

    if (!reset) begin
      sq.delete(); exp_wr.delete(); m_mis = 0;
    end else begin
      was_full = (cnt == DEPTH);
      drain = (cnt > 0 && sq[0].com && mem_wr_ready);
      a = alloc_base + alloc_imm;
      legal = (alloc_size != 2'b11) && (a % nbytes(alloc_size) == 0);
      m_mis = alloc_valid && !was_full && !legal;
      if (retire_valid) begin
        pend = -1;
        foreach (sq[j]) if (pend < 0 && !sq[j].com) pend = j;
        if (pend >= 0 && sq[pend].tag == rob_head) begin
          sq[pend].com = 1;
          off = int'(sq[pend].addr % 4);
          w.addr = sq[pend].addr & 32'hFFFF_FFFC;
          w.data = sq[pend].data << (8 * off);
          w.be   = 4'(((1 << sq[pend].nb) - 1) << off);
          exp_wr.push_back(w);
        end
      end
      if (drain) void'(sq.pop_front());
      if (flush) while (sq.size() > 0 && !sq[$].com) void'(sq.pop_back());
      if (alloc_valid && !was_full && !flush && legal) begin
        e.addr = a; e.data = alloc_data; e.nb = nbytes(alloc_size); e.tag = alloc_rob_tag; e.com = 0;
        sq.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  // Write monitor: pops the expected write whenever the DUT completes a handshake.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      #3;
      if (reset && mem_wr_valid && mem_wr_ready) begin
        if (exp_wr.size() == 0) begin
          n_checks++;
          $display("FAIL wr_unexpected: got write addr %0h, expected no write", mem_wr_addr);
        end else begin
          w = exp_wr.pop_front();
          chk("wr_addr", mem_wr_addr, w.addr);
          chk("wr_data", mem_wr_data, w.data);
          chk("wr_be", 32'(mem_wr_be), 32'(w.be));
        end
      end
    end
  end

  task automatic rand_inputs();
    int r, nb;
    idle();
    reset = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
    alloc_valid = ($urandom_range(0, 99) < 55);
    alloc_rob_tag = ROB_W'($urandom);
    alloc_base = 32'h40 + 32'($urandom_range(0, 7) * 4);
    alloc_size = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    nb = nbytes(alloc_size);
    r = $urandom_range(0, 3);
    alloc_imm = ($urandom_range(0, 99) < 85) ? 32'((r / nb) * nb) : 32'(r);
    alloc_data = $urandom;
    retire_valid = ($urandom_range(0, 99) < 45);
    rob_head = ROB_W'($urandom);
    if ($urandom_range(0, 99) < 80)
      foreach (sq[j]) if (!sq[j].com) begin rob_head = sq[j].tag; break; end
    flush = ($urandom_range(0, 99) < 3);
    mem_wr_ready = ($urandom_range(0, 99) < 50);
    ld_valid = ($urandom_range(0, 99) < 60);
    ld_size = 2'($urandom_range(0, 2));
    nb = nbytes(ld_size);
    ld_addr = 32'h40 + 32'(($urandom_range(0, 31) / nb) * nb);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    idle();
    reset = 1'b0;
    @(negedge clk);
    step(); step();
    idle();

    // sw 0x100+4, commit, drain
    store(5'd3, 32'h100, 32'h4, 32'hDEADBEEF, 2'b10); step();
    idle(); retire_valid = 1; rob_head = 5'd3; mem_wr_ready = 1; step();
    chk("s1_valid", 32'(mem_wr_valid), 32'd1);
    chk("s1_addr", mem_wr_addr, 32'h104);
    chk("s1_be", 32'(mem_wr_be), 32'hF);
    chk("s1_data", mem_wr_data, 32'hDEADBEEF);
    idle(); mem_wr_ready = 1; step();
    chk("s1_empty", 32'(empty), 32'd1);

    // sb to 0x203
    store(5'd5, 32'h200, 32'h3, 32'h000000AB, 2'b00); step();
    idle(); retire_valid = 1; rob_head = 5'd5; step();
    chk("s2_be", 32'(mem_wr_be), 32'h8);
    chk("s2_data", mem_wr_data, 32'hAB000000);
    chk("s2_addr", mem_wr_addr, 32'h200);
    idle(); mem_wr_ready = 1; step();

    // misaligned sh to 0x401
    idle(); store(5'd6, 32'h400, 32'h1, 32'h1234, 2'b01); step();
    chk("s3_mis", 32'(misalign_err), 32'd1);
    chk("s3_count", 32'(count), 32'd0);
    idle(); step();
    chk("s3_mis_clear", 32'(misalign_err), 32'd0);

    // forwarding
    store(5'd7, 32'h300, 32'h0, 32'h11223344, 2'b10); step();
    idle(); ld_valid = 1; ld_addr = 32'h302; ld_size = 2'b01; #1;
    chk("s4_hit", 32'(fwd_hit), 32'd1);
    chk("s4_data", fwd_data, 32'h00001122);
    step();
    idle(); store(5'd8, 32'h300, 32'h3, 32'h55, 2'b00); step();
    idle(); ld_valid = 1; ld_addr = 32'h300; ld_size = 2'b10; #1;
    chk("s4_stall", 32'(fwd_stall), 32'd1);
    chk("s4_nohit", 32'(fwd_hit), 32'd0);
    step();
    idle(); flush = 1; step();
    idle(); step();

    // fill to full, 9th alloc ignored, then commit and drain with ready toggling
    for (int i = 0; i < DEPTH; i++) begin
      idle(); store(5'(i), 32'h500, 32'(4 * i), 32'hA000 + 32'(i), 2'b10); step();
    end
    idle(); store(5'd20, 32'h600, 32'h0, 32'h99, 2'b10); step();
    chk("s5_full", 32'(full), 32'd1);
    chk("s5_count", 32'(count), 32'd8);
    guard = 0;
    for (int i = 0; i < DEPTH; i++) begin
      idle(); retire_valid = 1; rob_head = 5'(i); mem_wr_ready = (i % 2 == 0); step();
    end
    while (!empty && guard < 60) begin
      idle(); mem_wr_ready = (guard % 2 == 0); step(); guard++;
    end
    chk("s5_drained", 32'(empty), 32'd1);

    // tags 1..4, commit 1 and 2, flush with same-cycle alloc
    for (int i = 1; i <= 4; i++) begin
      idle(); store(5'(i), 32'h700, 32'(4 * i), 32'hB000 + 32'(i), 2'b10); step();
    end
    idle(); retire_valid = 1; rob_head = 5'd1; step();
    idle(); retire_valid = 1; rob_head = 5'd2; step();
    idle(); flush = 1; store(5'd9, 32'h800, 32'h0, 32'hC0, 2'b10); step();
    chk("s6_count", 32'(count), 32'd2);
    idle(); store(5'd10, 32'h900, 32'h0, 32'hD0, 2'b10); step();
    chk("s6_count_after_alloc", 32'(count), 32'd3);
    idle(); retire_valid = 1; rob_head = 5'd10; mem_wr_ready = 1; step();
    guard = 0;
    while (!empty && guard < 20) begin
      idle(); mem_wr_ready = 1; step(); guard++;
    end
    chk("s6_empty", 32'(empty), 32'd1);

    // reset while a committed write is stalled
    idle(); store(5'd11, 32'hA00, 32'h0, 32'hE0, 2'b10); step();
    idle(); retire_valid = 1; rob_head = 5'd11; step();
    chk("s7_valid", 32'(mem_wr_valid), 32'd1);
    idle(); reset = 0; step();
    chk("s7_discard", 32'(mem_wr_valid), 32'd0);
    idle(); mem_wr_ready = 1; step();
    chk("s7_empty", 32'(empty), 32'd1);

    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/store_queue.md
STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the entry count; it is a power of 2 and at least 2.
REQ-002 The block SHALL have parameter ROB_W, default 5, meaning the ROB tag width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have the alloc_* ports, all inputs:
- alloc_valid, 1 bit: store issue request.
- alloc_rob_tag, ROB_W bits.
- alloc_base, 32 bits: rs1 value.
- alloc_imm, 32 bits.
- alloc_data, 32 bits: rs2 value.
- alloc_size, 2 bits: 00=sb, 01=sh, 10=sw; 11 is illegal.
REQ-006 The block SHALL have the commit ports, both inputs:
- retire_valid, 1 bit.
- rob_head, ROB_W bits.
REQ-007 The block SHALL have port flush, input, 1 bit: mispredict/exception squash.
REQ-008 The block SHALL have the memory write port:
- Outputs: mem_wr_valid (1 bit), mem_wr_addr (32 bits, word-aligned), mem_wr_data (32 bits, lane-aligned), mem_wr_be (4 bits).
- Input: mem_wr_ready (1 bit).
REQ-009 The block SHALL have the load query ports:
- Inputs: ld_valid (1 bit), ld_addr (32 bits), ld_size (2 bits).
- Outputs: fwd_hit (1 bit), fwd_data (32 bits, right-justified, zero-extended), fwd_stall (1 bit).
REQ-010 The block SHALL have these status outputs:
- full (1 bit).
- empty (1 bit).
- count ($clog2(DEPTH)+1 bits).
- misalign_err (1 bit, registered pulse).

Function
REQ-011 Each entry SHALL be in one of three states: FREE, PENDING or COMMITTED; from head to tail, COMMITTED entries form a contiguous prefix followed by PENDING entries.
REQ-012 Allocation SHALL occur when alloc_valid=1, full=0, flush=0, alloc_size!=11 and the address is aligned.
- The entry is written at tail in state PENDING.
- addr = alloc_base+alloc_imm, modulo 2^32.
- tail advances modulo DEPTH.
REQ-013 A misaligned address (sh with addr[0]=1, sw with addr[1:0]!=0) or alloc_size=11, with alloc_valid=1 and full=0, SHALL be dropped and SHALL pulse misalign_err high for exactly the next cycle.
REQ-014 alloc_valid while full=1 SHALL be ignored without error, even if a drain occurs in the same cycle.
REQ-015 On retire_valid=1, the oldest PENDING entry SHALL become COMMITTED if its tag equals rob_head; otherwise nothing happens; at most one entry commits per cycle.
REQ-016 mem_wr_valid SHALL equal 1 exactly when the head entry is COMMITTED.
- The mem_wr_* outputs are driven combinationally from the head entry.
- The head is dequeued on mem_wr_valid & mem_wr_ready.
- Entry contents SHALL be held stable while valid=1 and ready=0.
REQ-017 The memory write outputs SHALL be formed as:
- mem_wr_be = {0001, 0011, 1111} for {sb, sh, sw}, shifted left by addr[1:0].
- mem_wr_data = data shifted left by 8*addr[1:0].
- mem_wr_addr = {addr[31:2], 2'b00}.
REQ-018 On flush=1, all PENDING entries SHALL become FREE and tail SHALL rewind to head + committed_count, modulo DEPTH; COMMITTED entries survive and keep draining.
REQ-019 When flush coincides with other events:
- Allocation in the same cycle is dropped.
- A retire in the same cycle is applied first, so that entry survives.
- A drain in the same cycle proceeds.
REQ-020 Load forwarding SHALL be purely combinational over all non-FREE entries, and all three forwarding outputs SHALL be 0 when ld_valid=0.
- If the youngest byte-overlapping entry covers every load byte: fwd_hit=1 and fwd_data = that entry's bytes for the load.
- If any overlapping entry lacks full coverage: fwd_stall=1 and fwd_hit=0.
- If no entry overlaps: both are 0.
REQ-021 count SHALL equal the number of non-FREE entries; full=(count==DEPTH); empty=(count==0).
- count is updated in the same edge for a simultaneous alloc and dequeue (net unchanged).
- Head and tail wrap from DEPTH-1 to 0.

Reset
REQ-022 When reset=0 at a rising clk edge, the block SHALL set:
- all entries to FREE;
- head=tail=0 and count=0;
- empty=1, full=0, mem_wr_valid=0, misalign_err=0.
REQ-023 A reset asserted mid-drain with mem_wr_ready=0 SHALL discard the entry without issuing a write.

Verification
REQ-024 Scenario: sw with base=0x100, imm=4, data=0xDEADBEEF, tag 3; then retire with rob_head=3; ready=1.
- Required: next cycle mem_wr_valid=1, addr=0x104, be=1111, data=0xDEADBEEF.
- Required: after the handshake, empty=1.
REQ-025 Scenario: sb to 0x203 with data=0x000000AB.
- Required: be=1000, data=0xAB000000, addr=0x200.
REQ-026 Scenario: allocate 8 stores with DEPTH=8.
- Required: full=1 and a 9th alloc is ignored, count=8.
- Then commit and drain all with ready toggling 1/0: writes appear in order, head wraps, empty=1.
REQ-027 Scenario: tags 1..4 allocated, tags 1 and 2 committed, then flush.
- Required: count=2, tail=head+2, entries 1 and 2 still drain.
- Required: a same-cycle alloc is dropped.
REQ-028 Scenario: pending sw 0x11223344 at 0x300.
- Required: lh at 0x302 gives fwd_hit=1, fwd_data=0x00001122.
- Required: after a younger sb at 0x303 is added, lw at 0x300 gives fwd_stall=1.
REQ-029 Scenario: sh to 0x401.
- Required: misalign_err=1 for one cycle and count unchanged.
